// File: rtl/npc_unit_pkg.sv
// Shared opcode encodings and default addresses for the next-PC unit.
package npc_unit_pkg;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;
  localparam logic [2:0] NPC_ERET   = 3'd4;

  localparam logic [31:0] NPC_DEFAULT_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NPC_DEFAULT_EXC_VEC  = 32'h0000_4180;

endpackage

// File: rtl/npc_target.sv
// Combinational redirect-target computation and misaligned-target detection.
// Opcodes 5-7 decode as no redirect, so they fall through to sequential fetch.
module npc_target
  import npc_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       npc_op,
  input  logic             br_taken,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] pc_plus4,
  input  logic [WIDTH-1:0] epc,
  output logic [WIDTH-1:0] target,
  output logic             redirect,
  output logic             misaligned
);

  logic [WIDTH-1:0] br_offset;
  logic [WIDTH-1:0] jump_target;

  // Word offset sign-extended to a byte offset.
  assign br_offset = {{(WIDTH-18){imm26[15]}}, imm26[15:0], 2'b00};

  // The jump keeps the upper region bits of pc+4 above bit 27, if any exist.
  generate
    if (WIDTH > 28) begin : g_region
      assign jump_target = {pc_plus4[WIDTH-1:28], imm26, 2'b00};
    end else begin : g_no_region
      assign jump_target = {imm26, 2'b00};
    end
  endgenerate

  // Select the target, flag whether this op redirects, and check JR/ERET alignment.
  always_comb begin
    target     = pc_plus4;
    redirect   = 1'b0;
    misaligned = 1'b0;
    case (npc_op)
      NPC_BRANCH: begin
        target   = pc_plus4 + br_offset;
        redirect = br_taken;
      end
      NPC_JUMP: begin
        target   = jump_target;
        redirect = 1'b1;
      end
      NPC_JR: begin
        target     = rs_data;
        redirect   = 1'b1;
        misaligned = (rs_data[1:0] != 2'b00);
      end
      NPC_ERET: begin
        target     = epc;
        redirect   = 1'b1;
        misaligned = (epc[1:0] != 2'b00);
      end
      default: begin
        target   = pc_plus4;
        redirect = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/npc_unit.sv
// Next-PC generator: PC and EPC registers, exception entry/return, a one-entry
// buffer that defers a redirect seen during a stall, and misaligned-target traps.
module npc_unit
  import npc_unit_pkg::*;
#(
  parameter int          WIDTH    = 32,
  parameter logic [31:0] RESET_PC = NPC_DEFAULT_RESET_PC,
  parameter logic [31:0] EXC_VEC  = NPC_DEFAULT_EXC_VEC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [2:0]       npc_op,
  input  logic             br_taken,
  input  logic [25:0]      imm26,
  input  logic [WIDTH-1:0] rs_data,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic [WIDTH-1:0] epc,
  output logic             pend_valid,
  output logic             addr_err
);

  localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] EXC_VEC_W  = WIDTH'(EXC_VEC);
  localparam logic [WIDTH-1:0] FOUR       = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic [WIDTH-1:0] pend_target_q, pend_target_d;
  logic             pend_valid_q, pend_valid_d;
  logic             addr_err_q, addr_err_d;

  logic [WIDTH-1:0] target;
  logic             redirect;
  logic             misaligned;

  assign pc_plus4 = pc_q + FOUR;

  npc_target #(
    .WIDTH(WIDTH)
  ) u_target (
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .imm26     (imm26),
    .rs_data   (rs_data),
    .pc_plus4  (pc_plus4),
    .epc       (epc_q),
    .target    (target),
    .redirect  (redirect),
    .misaligned(misaligned)
  );

  // Priority chain: exception, misaligned trap, stall capture/hold, pending replay,
  // redirect, sequential fetch. addr_err defaults low so it only ever pulses.
  always_comb begin
    pc_d          = pc_q;
    epc_d         = epc_q;
    pend_target_d = pend_target_q;
    pend_valid_d  = pend_valid_q;
    addr_err_d    = 1'b0;
    if (exc_req) begin
      epc_d        = pc_q;
      pc_d         = EXC_VEC_W;
      pend_valid_d = 1'b0;
    end else if (misaligned) begin
      addr_err_d   = 1'b1;
      epc_d        = pc_q;
      pc_d         = EXC_VEC_W;
      pend_valid_d = 1'b0;
    end else if (stall) begin
      // Only the first redirect of a stall window is kept.
      if (redirect && !pend_valid_q) begin
        pend_target_d = target;
        pend_valid_d  = 1'b1;
      end
    end else if (pend_valid_q) begin
      // The deferred redirect wins over whatever op is presented now.
      pc_d         = pend_target_q;
      pend_valid_d = 1'b0;
    end else if (redirect) begin
      pc_d = target;
    end else begin
      pc_d = pc_plus4;
    end
  end

  // State registers; reset also drops any pending redirect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC_W;
      epc_q         <= '0;
      pend_target_q <= '0;
      pend_valid_q  <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      epc_q         <= epc_d;
      pend_target_q <= pend_target_d;
      pend_valid_q  <= pend_valid_d;
      addr_err_q    <= addr_err_d;
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign pend_valid = pend_valid_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_npc_unit.sv
// Directed bench for npc_unit: sequential fetch, branch/jump/JR, stall deferral,
// exception entry/return, misaligned traps, wraparound and asynchronous reset.
module tb_npc_unit;

  localparam logic [2:0] OP_PLUS4  = 3'd0;
  localparam logic [2:0] OP_BRANCH = 3'd1;
  localparam logic [2:0] OP_JUMP   = 3'd2;
  localparam logic [2:0] OP_JR     = 3'd3;
  localparam logic [2:0] OP_ERET   = 3'd4;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [2:0]  npc_op;
  logic        br_taken;
  logic [25:0] imm26;
  logic [31:0] rs_data;
  logic        exc_req;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        pend_valid;
  logic        addr_err;

  int n_checks = 0;
  int n_errors = 0;

  npc_unit #(
    .WIDTH   (32),
    .RESET_PC(32'h0000_3000),
    .EXC_VEC (32'h0000_4180)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .npc_op    (npc_op),
    .br_taken  (br_taken),
    .imm26     (imm26),
    .rs_data   (rs_data),
    .exc_req   (exc_req),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .epc       (epc),
    .pend_valid(pend_valid),
    .addr_err  (addr_err)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one set of inputs across a rising edge, then settle 1 unit past it.
  task automatic step(input logic s, input logic [2:0] op, input logic bt,
                      input logic [25:0] imm, input logic [31:0] rs, input logic exc);
    stall    = s;
    npc_op   = op;
    br_taken = bt;
    imm26    = imm;
    rs_data  = rs;
    exc_req  = exc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    npc_op   = OP_PLUS4;
    br_taken = 1'b0;
    imm26    = '0;
    rs_data  = '0;
    exc_req  = 1'b0;

    // Reset state
    #12;
    check("rst_pc", pc, 32'h0000_3000);
    check("rst_epc", epc, 32'h0);
    check("rst_pend", {31'b0, pend_valid}, 32'h0);
    check("rst_addr_err", {31'b0, addr_err}, 32'h0);
    rst = 1'b0;
    #1;
    check("pc_plus4_comb", pc_plus4, 32'h0000_3004);

    // Sequential fetch
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("plus4_1", pc, 32'h0000_3004);
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("plus4_2", pc, 32'h0000_3008);
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("plus4_3", pc, 32'h0000_300C);
    step(1'b0, 3'd6, 1'b0, 26'h0, 32'h0, 1'b0);
    check("op6_as_plus4", pc, 32'h0000_3010);

    // Branch taken backwards: 0x3014 - 8
    step(1'b0, OP_BRANCH, 1'b1, 26'h000_FFFE, 32'h0, 1'b0);
    check("branch_taken", pc, 32'h0000_300C);
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("back_to_3010", pc, 32'h0000_3010);
    step(1'b0, OP_BRANCH, 1'b0, 26'h000_FFFE, 32'h0, 1'b0);
    check("branch_not_taken", pc, 32'h0000_3014);
    step(1'b0, OP_JR, 1'b0, 26'h0, 32'h0000_3010, 1'b0);
    check("jr_3010", pc, 32'h0000_3010);
    step(1'b0, OP_JUMP, 1'b0, 26'h000_0C40, 32'h0, 1'b0);
    check("jump", pc, 32'h0000_3100);
    check("jump_no_err", {31'b0, addr_err}, 32'h0);

    // Stall window: first redirect (JR) kept, second (JUMP) dropped
    step(1'b1, OP_JR, 1'b0, 26'h0, 32'h0000_4000, 1'b0);
    check("stall1_pc", pc, 32'h0000_3100);
    check("stall1_pend", {31'b0, pend_valid}, 32'h1);
    step(1'b1, OP_JUMP, 1'b0, 26'h000_0100, 32'h0, 1'b0);
    check("stall2_pc", pc, 32'h0000_3100);
    check("stall2_pend", {31'b0, pend_valid}, 32'h1);
    step(1'b1, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("stall3_pc", pc, 32'h0000_3100);
    // Release with a JUMP presented; the pending JR must win
    step(1'b0, OP_JUMP, 1'b0, 26'h000_0100, 32'h0, 1'b0);
    check("pend_replay_pc", pc, 32'h0000_4000);
    check("pend_replay_clr", {31'b0, pend_valid}, 32'h0);
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("after_replay", pc, 32'h0000_4004);

    // Exception during stall with a pending redirect, then ERET
    step(1'b0, OP_JR, 1'b0, 26'h0, 32'h0000_3020, 1'b0);
    check("jr_3020", pc, 32'h0000_3020);
    step(1'b1, OP_JR, 1'b0, 26'h0, 32'h0000_5000, 1'b0);
    check("exc_pre_pend", {31'b0, pend_valid}, 32'h1);
    step(1'b1, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b1);
    check("exc_pc", pc, 32'h0000_4180);
    check("exc_epc", epc, 32'h0000_3020);
    check("exc_pend_clr", {31'b0, pend_valid}, 32'h0);
    step(1'b0, OP_ERET, 1'b0, 26'h0, 32'h0, 1'b0);
    check("eret_pc", pc, 32'h0000_3020);
    check("eret_epc_kept", epc, 32'h0000_3020);

    // Misaligned JR traps for one cycle
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("pre_mis_pc", pc, 32'h0000_3024);
    step(1'b0, OP_JR, 1'b0, 26'h0, 32'h0000_4002, 1'b0);
    check("mis_addr_err", {31'b0, addr_err}, 32'h1);
    check("mis_pc", pc, 32'h0000_4180);
    check("mis_epc", epc, 32'h0000_3024);
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("mis_pulse_end", {31'b0, addr_err}, 32'h0);
    check("mis_next_pc", pc, 32'h0000_4184);

    // Misaligned JR while stalled still traps
    step(1'b1, OP_JR, 1'b0, 26'h0, 32'h0000_5001, 1'b0);
    check("mis_stall_err", {31'b0, addr_err}, 32'h1);
    check("mis_stall_pc", pc, 32'h0000_4180);
    check("mis_stall_epc", epc, 32'h0000_4184);
    check("mis_stall_nopend", {31'b0, pend_valid}, 32'h0);

    // Wraparound at the top of the address space
    step(1'b0, OP_JR, 1'b0, 26'h0, 32'hFFFF_FFFC, 1'b0);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_err_clr", {31'b0, addr_err}, 32'h0);
    check("wrap_plus4_comb", pc_plus4, 32'h0000_0000);
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("wrap_plus4", pc, 32'h0000_0000);

    // Asynchronous reset drops a pending redirect without a clock edge
    step(1'b0, OP_JR, 1'b0, 26'h0, 32'h0000_3040, 1'b0);
    step(1'b1, OP_JR, 1'b0, 26'h0, 32'h0000_6000, 1'b0);
    check("arst_pre_pend", {31'b0, pend_valid}, 32'h1);
    check("arst_pre_pc", pc, 32'h0000_3040);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", pc, 32'h0000_3000);
    check("arst_pend", {31'b0, pend_valid}, 32'h0);
    #1;
    rst = 1'b0;
    step(1'b0, OP_PLUS4, 1'b0, 26'h0, 32'h0, 1'b0);
    check("arst_after", pc, 32'h0000_3004);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/npc_unit.md
Name: npc_unit

Overview:
Parametrised next-PC generator with the PC register built in. It is the successor to the combinational next-PC selector. Adds register-indirect jumps, exception entry and return with an internal EPC, stall handling with a one-entry pending-redirect buffer, and misaligned-target detection. Sits at the head of the fetch stage and drives the instruction-memory address.

Parameters:
WIDTH, 32, address width in bits; must be >= 28
RESET_PC, 32'h0000_3000, PC value loaded on reset (truncated to WIDTH)
EXC_VEC, 32'h0000_4180, exception entry address (truncated to WIDTH)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
stall  in  1  hold PC; redirects arriving now are deferred
npc_op  in  3  0 PLUS4, 1 BRANCH, 2 JUMP, 3 JR, 4 ERET; 5-7 treated as PLUS4
br_taken  in  1  BRANCH condition; BRANCH with br_taken=0 behaves as PLUS4
imm26  in  26  [15:0] branch offset in words, [25:0] jump index
rs_data  in  WIDTH  JR target
exc_req  in  1  exception request, highest priority
pc  out  WIDTH  current fetch PC (register)
pc_plus4  out  WIDTH  pc+4, combinational
epc  out  WIDTH  saved exception PC (register)
pend_valid  out  1  deferred redirect held
addr_err  out  1  one-cycle pulse: misaligned JR/ERET target

Behaviour:
- Reset is asynchronous and active-high on rst; the only clock is clk.
- Reset values: pc=RESET_PC, epc=0, pend_valid=0, pend_target=0, addr_err=0.
- Arithmetic is modulo 2^WIDTH; carries out of the MSB are dropped.
- Targets are computed combinationally from the current pc:
  - BRANCH: pc+4 + (sign-extended imm26[15:0] << 2)
  - JUMP: {pc_plus4[WIDTH-1:28], imm26, 2'b00}
  - JR: rs_data
  - ERET: epc
- A redirect is BRANCH with br_taken=1, JUMP, JR or ERET.
- Misaligned means a JR or ERET target with bits [1:0] != 0.
- Priority each rising clk edge, first match wins:
  1. exc_req=1 (stall ignored): epc<=pc; pc<=EXC_VEC; pend_valid<=0.
  2. Misaligned redirect (stall ignored): addr_err<=1; epc<=pc; pc<=EXC_VEC; pend_valid<=0.
  3. stall=1 with a redirect and pend_valid=0: pend_target<=target; pend_valid<=1; pc held.
  4. stall=1 otherwise: pc held. A second redirect while pend_valid=1 is dropped; the first one wins.
  5. stall=0 with pend_valid=1: pc<=pend_target; pend_valid<=0. Any npc_op this cycle is ignored.
  6. stall=0 with a redirect: pc<=target.
  7. Otherwise: pc<=pc+4.
- addr_err is 0 on every edge where rule 2 does not fire, so it is exactly a one-cycle pulse.
- ERET taken while stalled captures the epc value at capture time. A later exception does not alter a deferred ERET, because the exception clears it.
- Latency:
  - A redirect is visible on pc one cycle after it is presented.
  - A deferred redirect is visible one cycle after stall deasserts.
- pc_plus4 has no register stage.
- Reset mid-stall or mid-pending discards the pending redirect immediately, asynchronously.

Decomposition:
- Shared package/header: NPC_PLUS4, NPC_BRANCH, NPC_JUMP, NPC_JR, NPC_ERET opcode constants (3 bits). Also the default RESET_PC and EXC_VEC values.
- One natural sub-module, npc_target: purely combinational target computation plus the misalignment flag. The parent holds the pc, epc and pending registers and the priority logic.

Test Plan:
- Reset, then 3 cycles of PLUS4 -> pc 0x3000, 0x3004, 0x3008, 0x300C. Separately, force pc to 0xFFFF_FFFC and apply PLUS4 -> pc 0x0000_0000.
- At pc=0x3010, BRANCH with br_taken=1 and imm=0xFFFE -> pc 0x300C. The same op with br_taken=0 -> pc 0x3014. At pc=0x3010, JUMP with imm26=0x0000C40 -> pc 0x0000_3100.
- stall=1 for 3 cycles, JR rs_data=0x4000 in the first stall cycle and JUMP in the second -> pend_valid=1 and pc held. When stall drops, pc becomes 0x4000; the JUMP is dropped.
- At pc=0x3020, exc_req while stall=1 with a pending redirect -> next pc 0x4180, epc 0x3020, pend_valid 0. Then ERET -> pc 0x3020.
- JR with rs_data=0x4002 -> addr_err high for exactly one cycle, pc 0x4180, epc equals the PC of the issuing cycle.
- Assert rst asynchronously while pend_valid=1 -> pc 0x3000 and pend_valid 0 without waiting for a clk edge.
